lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit that executes the load/store control codes produced by instruction decode (load_type, store_type, mem_write) against a word-wide data memory.
- The memory has no byte enables, so sb/sh are done as read-modify-write.
- Handles lane select, sign/zero extension, misalignment and illegal-code detection, and a memory-ack timeout.
- Sits between the CPU execute stage and data memory.

Parameters:
- TIMEOUT, 255, cycles to wait for mem_ack in one memory state before aborting with error (1..65535).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU access request
- req_ready  output  1  unit idle, can accept
- mem_write  input  1  1 = store, 0 = load
- load_type  input  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- store_type  input  2  00 sw, 01 sh, 10 sb
- addr  input  32  byte address
- wdata  input  32  store data (low bits used for sb/sh)
- rsp_valid  output  1  response available
- rsp_ready  input  1  CPU accepts response
- rdata  output  32  extended load result (0 for stores/errors)
- err  output  1  misaligned, illegal code, or timeout; qualified by rsp_valid
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_wdata  output  32  full write word
- mem_ack  input  1  transaction complete; mem_rdata valid same cycle for reads
- mem_rdata  input  32  read word

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rdata=0; err=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; timeout counter 0.
- Reset during any state aborts immediately: no response is issued, mem_req drops next cycle.
- States: IDLE, RD, WR, RESP.
- req_ready=1 only in IDLE. A request is accepted on req_valid && req_ready; addr, wdata and the type codes are captured at acceptance.
- Illegal codes: load_type 101..111, or store_type 11.
- Misaligned accesses:
  - lh/lhu/sh with addr[0]=1.
  - lw/sw with addr[1:0]!=0.
- IDLE transitions on accept:
  - illegal or misaligned -> RESP with err=1, rdata=0, no mem_req.
  - load or sb/sh -> RD.
  - sw -> WR with mem_wdata=wdata.
- mem_req=1 throughout RD and WR. mem_we=1 only in WR. mem_addr and mem_wdata stay stable while mem_req=1.
- Each cycle with mem_req && mem_ack completes exactly one transaction. Back-to-back RD->WR keeps mem_req high, and the memory treats the next cycle as a new transaction.
- RD on ack:
  - load: form rdata from mem_rdata -> RESP.
  - sb/sh: merge -> WR.
- Lanes are little-endian.
  - Byte loads: byte = mem_rdata[8*addr[1:0] +: 8]. lb sign-extends bit 7; lbu zero-extends.
  - Half loads: half = mem_rdata[16*addr[1] +: 16]. lh sign-extends bit 15; lhu zero-extends.
  - lw: rdata = mem_rdata.
  - sb: replace lane addr[1:0] with wdata[7:0].
  - sh: replace half addr[1] with wdata[15:0]. Other bytes keep their read values.
- WR on ack -> RESP with rdata=0, err=0.
- Timeout counter:
  - clears on entry to RD or WR and increments each non-ack cycle.
  - reaching TIMEOUT without ack -> RESP with err=1, rdata=0, mem_req=0.
  - a timeout in the RD of sb/sh issues no write.
- RESP: rsp_valid=1; rdata and err are held until rsp_ready. On rsp_valid && rsp_ready -> IDLE, rsp_valid=0 next cycle. A new request is accepted no earlier than the cycle after the response handshake.
- Minimum latency (accept to rsp_valid):
  - load: 2 cycles with same-cycle ack.
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - error: 1 cycle.

Test Plan:
- lb, addr=0x103, mem_rdata=0x80AA_1234, ack on 1st RD cycle -> mem_addr=0x100, mem_we=0, rdata=0xFFFF_FF80, err=0, rsp_valid 2 cycles after accept.
- lhu addr=0x102 then lh addr=0x100, mem_rdata=0x9ABC_8001 -> rdata 0x0000_9ABC, then 0xFFFF_8001.
- sb addr=0x201, wdata=0xDEAD_BE5A, read returns 0x1122_3344 -> one read of 0x200, then write mem_wdata=0x1122_5A44, mem_we=1, err=0; sh addr=0x202 wdata=0x0000_CAFE same read -> write 0xCAFE_3344.
- lw addr=0x302; sh addr=0x301; store_type=11 -> each gives rsp_valid after 1 cycle, err=1, rdata=0, mem_req never asserted.
- TIMEOUT=4, sb with mem_ack held low -> mem_req high for 4 cycles, then err=1, no write issued; rsp_ready held low 3 cycles -> rsp_valid, rdata and err stable throughout.
- reset asserted in WR with ack pending -> next cycle all outputs at reset values, req_ready=1; a following sw addr=0x400 wdata=0x5 -> single write 0x0000_0005 to 0x400.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a word-wide data memory without byte enables.
// Sub-word stores are performed as read-modify-write; loads are lane-selected and extended.
module lsu_mem_port #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_write,
   input  logic [2:0]  load_type,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [15:0] wlo_q, wlo_d;
   logic        write_q, write_d;
   logic [2:0]  ltype_q, ltype_d;
   logic [1:0]  stype_q, stype_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwdata_q, mwdata_d;
   logic [15:0] cnt_q, cnt_d;

   logic        illegal, misaligned;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic [31:0] merged;

   always_comb begin
      illegal    = mem_write ? (store_type == 2'b11) : (load_type > 3'd4);
      misaligned = 1'b0;
      if (mem_write) begin
         case (store_type)
            2'b00:   misaligned = (addr[1:0] != 2'b00);
            2'b01:   misaligned = addr[0];
            default: misaligned = 1'b0;
         endcase
      end else begin
         case (load_type)
            3'd1, 3'd4: misaligned = addr[0];
            3'd2:       misaligned = (addr[1:0] != 2'b00);
            default:    misaligned = 1'b0;
         endcase
      end
   end

   always_comb begin
      ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
      ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (ltype_q)
         3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
         3'd3:    ld_val = {24'd0, ld_byte};
         3'd4:    ld_val = {16'd0, ld_half};
         default: ld_val = mem_rdata;
      endcase
   end

   // Per-lane merge of the store data into the word just read back.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign merged[8*gi +: 8] =
         (stype_q == 2'b10 && off_q == LANE)       ? wlo_q[7:0] :
         (stype_q == 2'b01 && off_q[1] == LANE[1]) ? wlo_q[8*(gi%2) +: 8] :
                                                     mem_rdata[8*gi +: 8];
   end

   always_comb begin
      state_d  = state_q;
      off_d    = off_q;
      wlo_d    = wlo_q;
      write_d  = write_q;
      ltype_d  = ltype_q;
      stype_d  = stype_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: if (req_valid) begin
            off_d   = addr[1:0];
            wlo_d   = wdata[15:0];
            write_d = mem_write;
            ltype_d = load_type;
            stype_d = store_type;
            if (illegal || misaligned) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else begin
               maddr_d = {addr[31:2], 2'b00};
               cnt_d   = 16'd0;
               if (mem_write && store_type == 2'b00) begin
                  state_d  = S_WR;
                  mwdata_d = wdata;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: if (mem_ack) begin
            cnt_d = 16'd0;
            if (write_q) begin
               mwdata_d = merged;
               state_d  = S_WR;
            end else begin
               rdata_d = ld_val;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
         end else if (cnt_q == TO_LAST) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
         S_WR: if (mem_ack) begin
            state_d = S_RESP;
            err_d   = 1'b0;
            rdata_d = 32'd0;
         end else if (cnt_q == TO_LAST) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
         S_RESP: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         off_q    <= 2'd0;
         wlo_q    <= 16'd0;
         write_q  <= 1'b0;
         ltype_q  <= 3'd0;
         stype_q  <= 2'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         maddr_q  <= 32'd0;
         mwdata_q <= 32'd0;
         cnt_q    <= 16'd0;
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         wlo_q    <= wlo_d;
         write_q  <= write_d;
         ltype_q  <= ltype_d;
         stype_q  <= stype_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         cnt_q    <= cnt_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign mem_req   = (state_q == S_RD) || (state_q == S_WR);
   assign mem_we    = (state_q == S_WR);
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;
   assign rdata     = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: loads, sub-word stores, errors, timeout and reset abort.
// A tiny memory responder acks combinationally when enabled and logs completed transactions.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, mem_write, rsp_valid, rsp_ready, err;
   logic [2:0]  load_type;
   logic [1:0]  store_type;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic        ack_en;
   logic [31:0] rd_word;

   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0, wr_cnt = 0, req_cyc = 0, we_cyc = 0;
   logic [31:0] last_rd_addr = 32'd0, last_wr_addr = 32'd0, last_wr_data = 32'd0;

   always #5 clk = ~clk;

   assign mem_ack   = ack_en & mem_req;
   assign mem_rdata = rd_word;

   lsu_mem_port #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
      .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_req) req_cyc++;
      if (mem_req && mem_we) we_cyc++;
      if (mem_req && mem_ack) begin
         if (mem_we) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
         end else begin
            rd_cnt++;
            last_rd_addr = mem_addr;
         end
      end
   end

   task automatic send(input logic we, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] wd);
      req_valid  = 1'b1;
      mem_write  = we;
      load_type  = lt;
      store_type = st;
      addr       = a;
      wdata      = wd;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL send_req_ready: got %b expected 1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_rsp;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++; if (req_ready !== 1'b1)     begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0)     begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rdata !== 32'd0)        begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
      checks++; if (err !== 1'b0)           begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
      checks++; if (mem_req !== 1'b0)       begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
      checks++; if (mem_we !== 1'b0)        begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
      checks++; if (mem_addr !== 32'd0)     begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      checks++; if (mem_wdata !== 32'd0)    begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
      $display("txn reset done");
   endtask

   task automatic test_lb;
      int lat, rd0, wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      ack_en  = 1'b1;
      rd_word = 32'h80AA_1234;
      send(1'b0, 3'd0, 2'd0, 32'h0000_0103, 32'd0);
      checks++; if (mem_req !== 1'b1)          begin errors++; $display("FAIL lb_mem_req: got %b expected 1", mem_req); end
      checks++; if (mem_addr !== 32'h100)      begin errors++; $display("FAIL lb_mem_addr: got %h expected 00000100", mem_addr); end
      checks++; if (mem_we !== 1'b0)           begin errors++; $display("FAIL lb_mem_we: got %b expected 0", mem_we); end
      wait_rsp(lat);
      checks++; if (lat != 2)                  begin errors++; $display("FAIL lb_latency: got %0d expected 2", lat); end
      checks++; if (rdata !== 32'hFFFF_FF80)   begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", rdata); end
      checks++; if (err !== 1'b0)              begin errors++; $display("FAIL lb_err: got %b expected 0", err); end
      checks++; if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 0)
         begin errors++; $display("FAIL lb_txn_count: got reads=%0d writes=%0d expected 1/0", rd_cnt - rd0, wr_cnt - wr0); end
      $display("txn lb addr=00000103 rdata=%h err=%b lat=%0d", rdata, err, lat);
      finish_rsp();
   endtask

   task automatic test_half;
      int lat;
      rd_word = 32'h9ABC_8001;
      send(1'b0, 3'd4, 2'd0, 32'h0000_0102, 32'd0);
      wait_rsp(lat);
      checks++; if (rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_rdata: got %h expected 00009abc", rdata); end
      checks++; if (lat != 2)                begin errors++; $display("FAIL lhu_latency: got %0d expected 2", lat); end
      $display("txn lhu addr=00000102 rdata=%h err=%b lat=%0d", rdata, err, lat);
      finish_rsp();
      send(1'b0, 3'd1, 2'd0, 32'h0000_0100, 32'd0);
      wait_rsp(lat);
      checks++; if (rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8001", rdata); end
      checks++; if (err !== 1'b0)            begin errors++; $display("FAIL lh_err: got %b expected 0", err); end
      $display("txn lh addr=00000100 rdata=%h err=%b lat=%0d", rdata, err, lat);
      finish_rsp();
   endtask

   task automatic test_subword_store;
      int lat, rd0, wr0;
      rd_word = 32'h1122_3344;
      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b1, 3'd0, 2'b10, 32'h0000_0201, 32'hDEAD_BE5A);
      wait_rsp(lat);
      checks++; if (lat != 3)                    begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
      checks++; if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1)
         begin errors++; $display("FAIL sb_txn_count: got reads=%0d writes=%0d expected 1/1", rd_cnt - rd0, wr_cnt - wr0); end
      checks++; if (last_rd_addr !== 32'h200)    begin errors++; $display("FAIL sb_read_addr: got %h expected 00000200", last_rd_addr); end
      checks++; if (last_wr_addr !== 32'h200)    begin errors++; $display("FAIL sb_write_addr: got %h expected 00000200", last_wr_addr); end
      checks++; if (last_wr_data !== 32'h1122_5A44) begin errors++; $display("FAIL sb_write_data: got %h expected 11225a44", last_wr_data); end
      checks++; if (err !== 1'b0 || rdata !== 32'd0)
         begin errors++; $display("FAIL sb_rsp: got err=%b rdata=%h expected 0/0", err, rdata); end
      $display("txn sb addr=00000201 wrote=%h err=%b lat=%0d", last_wr_data, err, lat);
      finish_rsp();
      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b1, 3'd0, 2'b01, 32'h0000_0202, 32'h0000_CAFE);
      wait_rsp(lat);
      checks++; if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1)
         begin errors++; $display("FAIL sh_txn_count: got reads=%0d writes=%0d expected 1/1", rd_cnt - rd0, wr_cnt - wr0); end
      checks++; if (last_wr_data !== 32'hCAFE_3344) begin errors++; $display("FAIL sh_write_data: got %h expected cafe3344", last_wr_data); end
      checks++; if (err !== 1'b0)                begin errors++; $display("FAIL sh_err: got %b expected 0", err); end
      $display("txn sh addr=00000202 wrote=%h err=%b lat=%0d", last_wr_data, err, lat);
      finish_rsp();
   endtask

   task automatic test_errors;
      logic        we_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  lt_t [4] = '{3'd2, 3'd0, 3'd0, 3'd5};
      logic [1:0]  st_t [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
      logic [31:0] a_t  [4] = '{32'h302, 32'h301, 32'h300, 32'h300};
      int lat, rq0;
      for (int i = 0; i < 4; i++) begin
         rq0 = req_cyc;
         send(we_t[i], lt_t[i], st_t[i], a_t[i], 32'hFFFF_FFFF);
         wait_rsp(lat);
         checks++; if (lat != 1)         begin errors++; $display("FAIL err%0d_latency: got %0d expected 1", i, lat); end
         checks++; if (err !== 1'b1)     begin errors++; $display("FAIL err%0d_err: got %b expected 1", i, err); end
         checks++; if (rdata !== 32'd0)  begin errors++; $display("FAIL err%0d_rdata: got %h expected 0", i, rdata); end
         checks++; if (req_cyc != rq0)   begin errors++; $display("FAIL err%0d_mem_req: got %0d req cycles expected 0", i, req_cyc - rq0); end
         $display("txn error_case=%0d addr=%h err=%b lat=%0d", i, a_t[i], err, lat);
         finish_rsp();
      end
   endtask

   task automatic test_timeout;
      int lat, rq0, we0;
      ack_en = 1'b0;
      rq0 = req_cyc; we0 = we_cyc;
      send(1'b1, 3'd0, 2'b10, 32'h0000_0201, 32'h0000_00AB);
      wait_rsp(lat);
      checks++; if (req_cyc - rq0 != 4) begin errors++; $display("FAIL to_req_cycles: got %0d expected 4", req_cyc - rq0); end
      checks++; if (we_cyc != we0)      begin errors++; $display("FAIL to_write_issued: got %0d we cycles expected 0", we_cyc - we0); end
      checks++; if (lat != 5)           begin errors++; $display("FAIL to_latency: got %0d expected 5", lat); end
      checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL to_mem_req: got %b expected 0", mem_req); end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rsp_valid !== 1'b1 || err !== 1'b1 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL to_hold%0d: got valid=%b err=%b rdata=%h expected 1/1/0", c, rsp_valid, err, rdata);
         end
         @(negedge clk);
      end
      $display("txn sb_timeout addr=00000201 err=%b lat=%0d", err, lat);
      finish_rsp();
      ack_en = 1'b1;
   endtask

   task automatic test_reset_in_wr;
      int lat, rd0, wr0;
      ack_en = 1'b0;
      wr0 = wr_cnt;
      send(1'b1, 3'd0, 2'b00, 32'h0000_0500, 32'hAAAA_5555);
      checks++; if (mem_we !== 1'b1 || mem_req !== 1'b1)
         begin errors++; $display("FAIL rwr_in_wr: got req=%b we=%b expected 1/1", mem_req, mem_we); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rwr_hs: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0)      begin errors++; $display("FAIL rwr_mem_ctl: got req=%b we=%b expected 0/0", mem_req, mem_we); end
      checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rwr_mem_bus: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
      checks++; if (rdata !== 32'd0 || err !== 1'b0)          begin errors++; $display("FAIL rwr_rsp: got rdata=%h err=%b expected 0/0", rdata, err); end
      checks++; if (wr_cnt != wr0)      begin errors++; $display("FAIL rwr_aborted_write: got %0d writes expected 0", wr_cnt - wr0); end
      reset  = 1'b0;
      ack_en = 1'b1;
      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b1, 3'd0, 2'b00, 32'h0000_0400, 32'h0000_0005);
      wait_rsp(lat);
      checks++; if (lat != 2)           begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
      checks++; if (wr_cnt - wr0 != 1 || rd_cnt - rd0 != 0)
         begin errors++; $display("FAIL sw_txn_count: got reads=%0d writes=%0d expected 0/1", rd_cnt - rd0, wr_cnt - wr0); end
      checks++; if (last_wr_addr !== 32'h400 || last_wr_data !== 32'h5)
         begin errors++; $display("FAIL sw_write: got addr=%h data=%h expected 00000400/00000005", last_wr_addr, last_wr_data); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL sw_err: got %b expected 0", err); end
      $display("txn sw addr=00000400 wrote=%h err=%b lat=%0d", last_wr_data, err, lat);
      finish_rsp();
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      mem_write  = 1'b0;
      load_type  = 3'd0;
      store_type = 2'd0;
      addr       = 32'd0;
      wdata      = 32'd0;
      ack_en     = 1'b0;
      rd_word    = 32'd0;
      @(negedge clk);
      test_reset();
      test_lb();
      test_half();
      test_subword_store();
      test_errors();
      test_timeout();
      test_reset_in_wr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
